// File: rtl/fifo_wr_stream_adapter.sv
// Write-domain front end for the async FIFO: a 2-entry skid buffer, a full-safe write port and a packet-aligned flush.
// Optional statistics counters are built when FIFO_WR_STATS_EN is defined; otherwise the counter ports read 0.
module fifo_wr_stream_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  w_clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  fifo_full,
    output logic                  w_en,
    output logic [DATA_WIDTH-1:0] w_data,
    input  logic                  flush_req,
    output logic                  flush_busy,
    output logic                  flush_done,
    output logic [CNT_WIDTH-1:0]  words_written,
    output logic [CNT_WIDTH-1:0]  pkts_written,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);

    typedef enum logic [1:0] {RUN, WAIT_EOP, DRAIN, DONE} state_t;

    // The last flag is only stored when the packet counter needs it at write time.
`ifdef FIFO_WR_STATS_EN
    localparam int ENTRY_W = DATA_WIDTH + 1;
    logic [ENTRY_W-1:0] in_entry;
    assign in_entry = {in_last, in_data};
`else
    localparam int ENTRY_W = DATA_WIDTH;
    logic [ENTRY_W-1:0] in_entry;
    assign in_entry = in_data;
`endif

    state_t             state;
    logic [1:0]         count;
    logic               pkt_open;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] tail_entry;
    logic               push;
    logic               pop;

    assign in_ready   = (count != 2'd2) && (state == RUN || state == WAIT_EOP);
    assign w_en       = (count != 2'd0) && !fifo_full;
    assign w_data     = head_entry[DATA_WIDTH-1:0];
    assign push       = in_valid && in_ready;
    assign pop        = w_en;
    assign flush_busy = (state == WAIT_EOP) || (state == DRAIN);
    assign flush_done = (state == DONE);

    // Head is always entry 0; pops shift the tail forward so w_data only moves on a write or a push into empty.
    always_ff @(posedge w_clk) begin
        if (!resetn) begin
            head_entry <= '0;
            tail_entry <= '0;
            count      <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head_entry <= in_entry;
                    else               tail_entry <= in_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_entry <= tail_entry;
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_entry <= in_entry;
                    end else begin
                        head_entry <= tail_entry;
                        tail_entry <= in_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge w_clk) begin
        if (!resetn) begin
            state    <= RUN;
            pkt_open <= 1'b0;
        end else begin
            if (push) pkt_open <= !in_last;
            case (state)
                RUN:      if (flush_req) state <= pkt_open ? WAIT_EOP : DRAIN;
                WAIT_EOP: if (push && in_last) state <= DRAIN;
                DRAIN:    if (count == 2'd0) state <= DONE;
                DONE:     state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

`ifdef FIFO_WR_STATS_EN
    logic [CNT_WIDTH-1:0] words_q;
    logic [CNT_WIDTH-1:0] pkts_q;
    logic [CNT_WIDTH-1:0] stall_q;

    always_ff @(posedge w_clk) begin
        if (!resetn) begin
            words_q <= '0;
            pkts_q  <= '0;
            stall_q <= '0;
        end else begin
            if (pop) words_q <= words_q + CNT_WIDTH'(1);
            if (pop && head_entry[DATA_WIDTH]) pkts_q <= pkts_q + CNT_WIDTH'(1);
            if ((count != 2'd0) && fifo_full) stall_q <= stall_q + CNT_WIDTH'(1);
        end
    end

    assign words_written = words_q;
    assign pkts_written  = pkts_q;
    assign stall_cycles  = stall_q;
`else
    assign words_written = '0;
    assign pkts_written  = '0;
    assign stall_cycles  = '0;
`endif

endmodule

// File: doc/fifo_wr_stream_adapter.md
# fifo_wr_stream_adapter

Write-clock-domain front end for the asynchronous pipeline FIFO. It accepts a valid/ready word stream from the producing pipeline stage and buffers it in a 2-entry skid buffer. It drives the FIFO's `w_en`/`w_data` write port without ever writing while the FIFO reports full. It also provides a packet-aligned flush handshake, so the producer can quiesce the write side before a pointer reset.

## Interface
- `DATA_WIDTH`, 32, payload width; equals the FIFO `DATA_WIDTH`.
- `CNT_WIDTH`, 16, width of the statistics counters.
- `w_clk`  in  1  write-domain clock; all logic is posedge.
- `resetn`  in  1  reset: synchronous, active-low; clock `w_clk`.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  adapter can accept a word this cycle.
- `in_data`  in  DATA_WIDTH  upstream word.
- `in_last`  in  1  word is the final beat of a packet.
- `fifo_full`  in  1  FIFO full flag (registered inside the FIFO).
- `w_en`  out  1  FIFO write enable.
- `w_data`  out  DATA_WIDTH  FIFO write data.
- `flush_req`  in  1  one-cycle request to drain and quiesce.
- `flush_busy`  out  1  flush in progress (WAIT_EOP or DRAIN).
- `flush_done`  out  1  one-cycle pulse when the drain completes.
- `words_written`  out  CNT_WIDTH  count of FIFO writes.
- `pkts_written`  out  CNT_WIDTH  count of FIFO writes carrying `last`.
- `stall_cycles`  out  CNT_WIDTH  cycles with data buffered and `fifo_full`=1.

## Operation
- **Skid buffer.** 2 entries of {data, last}, FIFO-ordered, with occupancy `count` in 0..2.
- **Accept and write.**
  - Accept when `in_valid && in_ready`.
  - `w_en = (count != 0) && !fifo_full`.
  - `w_data` = head entry data.
  - A write pops the head entry.
- **Simultaneous push/pop.** When a push and a pop occur in the same cycle, `count` is unchanged and order is preserved. When `count`=0, the pushed word is not written in the same cycle; it is written on the next cycle at the earliest.
- **`in_ready`.** `in_ready = (count != 2) && (state == RUN || state == WAIT_EOP)`. It depends on registers only and has no combinational path from `in_valid` or `fifo_full`.
- **States.**
  - RUN: normal streaming.
    - `flush_req` with `pkt_open`=0 -> DRAIN.
    - `flush_req` with `pkt_open`=1 -> WAIT_EOP.
  - WAIT_EOP: keep accepting. Move to DRAIN on the cycle after a beat with `in_last`=1 is accepted.
  - DRAIN: `in_ready`=0; FIFO writes continue. When `count`=0 -> DONE.
  - DONE: `flush_done`=1 for exactly one cycle, then -> RUN.
- **`pkt_open`.**
  - Set on an accepted beat with `in_last`=0.
  - Cleared on an accepted beat with `in_last`=1.
  - Reset value 0.
- **Ignored flush requests.** `flush_req` is ignored outside RUN.
- **Flush on an empty, idle adapter.** `flush_req` in RUN with `count`=0 and `pkt_open`=0 goes RUN -> DRAIN -> DONE, so `flush_done` pulses 2 cycles after `flush_req`.
- **Counters.** Unsigned, wrap modulo 2^CNT_WIDTH, updated on `w_en` (words, pkts) or on stall cycles.

## Timing
- **Reset values** (on the edge where `resetn`=0):
  - `count`=0, state RUN, `pkt_open`=0.
  - `in_ready`=1, `w_en`=0, `w_data`=0.
  - `flush_busy`=0, `flush_done`=0.
  - All counters 0.
- **Reset mid-flush.** Reset in any state discards buffered words and returns to RUN with no `flush_done` pulse.
- **Latency.** An accepted word appears on `w_en`/`w_data` 1 cycle after acceptance if `fifo_full`=0.
- **Throughput.** One word per cycle is sustained while `fifo_full`=0.
- **Full backpressure.** While `fifo_full`=1, `w_en`=0 and `w_data` holds the head entry. At most 2 further words are accepted, then `in_ready` drops.
- **`w_data` stability.** `w_data` changes only after a write or a push into an empty buffer.
- **`flush_busy`.** `flush_busy`=1 exactly while the state is WAIT_EOP or DRAIN.

## Configuration
- Macro `FIFO_WR_STATS_EN`.
- **Defined:** `words_written`, `pkts_written` and `stall_cycles` count as specified.
- **Undefined:** the counter registers are not built. All three ports are tied to 0. The ports remain present.

## Test plan
- **Streaming.** Reset, then 8 beats `in_data`=0x0..0x7 with `fifo_full`=0 -> `w_en` for 8 consecutive cycles, in order, starting 1 cycle after the first accept. With the macro defined, `words_written`=8.
- **Backpressure.** Hold `fifo_full`=1 and present 5 beats -> 2 accepted, `in_ready`=0, `w_en`=0. Release `fifo_full` -> beats 0,1 are written and then the remaining 3 flow. `stall_cycles` equals the number of cycles held full with data buffered.
- **Packet-aligned flush.** Send beats A,B (`in_last`=0), then `flush_req`, then beat C (`in_last`=1) -> state WAIT_EOP accepts C, then DRAIN with `in_ready`=0. A,B,C are written, `flush_done` pulses once, and `pkts_written`=1.
- **Idle flush.** `flush_req` with an empty buffer and no open packet -> `flush_done` pulses exactly 2 cycles later; `flush_busy`=1 for 1 cycle.
- **Reset during DRAIN.** Reset while in DRAIN with `count`=2 and `fifo_full`=1 -> after reset, `count`=0, `in_ready`=1, no `flush_done` pulse, and all counters 0.
- **Simultaneous push/pop.** With `count`=1, push and write in the same cycle -> `count` stays 1 and the order is preserved (head written, new word next).
